fir_sym_pipe: RTL and testbench

//  Parametrised, pipelined, linear-phase (symmetric) FIR filter for the approximate-arithmetic datapath.

---
 rtl/fir_sym_pipe.sv | 107 ++++++++++
 tb/tb_fir_sym_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_sym_pipe.sv
// Linear-phase FIR with folded mirror taps, runtime-writable coefficients
// and a free-running four-stage pipeline behind a valid-gated delay line.
module fir_sym_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned N_TAPS = 9,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 0,
  parameter bit          SAT    = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  input  logic signed [DATA_W-1:0]               in_data,
  input  logic                                   coef_we,
  input  logic [$clog2((N_TAPS+1)/2)-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0]               coef_wdata,
  output logic                                   out_valid,
  output logic signed [OUT_W-1:0]                out_data
);

  localparam int unsigned M     = (N_TAPS + 1) / 2;
  localparam int unsigned AW    = $clog2(M);
  localparam int unsigned PW    = DATA_W + 1;
  localparam int unsigned MW    = DATA_W + COEF_W + 1;
  localparam int unsigned ACC_W = MW + $clog2(M);
  localparam int unsigned HW    = ACC_W - OUT_W + 1;

  logic signed [DATA_W-1:0] d    [N_TAPS];
  logic signed [COEF_W-1:0] coef [M];
  logic signed [PW-1:0]     p    [M];
  logic signed [MW-1:0]     m    [M];
  logic signed [ACC_W-1:0]  s;
  logic [3:0]               vld;

  logic signed [ACC_W-1:0]  acc_c;
  logic signed [ACC_W-1:0]  shifted_c;
  logic [HW-1:0]            hi_c;
  logic signed [OUT_W-1:0]  res_c;

  // Delay line advances only on accepted samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_TAPS); i++) d[i] <= '0;
    end else if (in_valid) begin
      d[0] <= in_data;
      for (int i = 1; i < int'(N_TAPS); i++) d[i] <= d[i-1];
    end
  end

  // Coefficient bank; reset to the identity filter, out-of-range writes dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(M); k++)
        coef[k] <= (k == int'(M) - 1) ? COEF_W'(1) : '0;
    end else if (coef_we) begin
      for (int k = 0; k < int'(M); k++)
        if (coef_addr == AW'(k)) coef[k] <= coef_wdata;
    end
  end

  // Pre-add, multiply and sum stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(M); k++) begin
        p[k] <= '0;
        m[k] <= '0;
      end
      s <= '0;
    end else begin
      for (int k = 0; k < int'(M) - 1; k++)
        p[k] <= PW'(d[k]) + PW'(d[int'(N_TAPS) - 1 - k]);
      p[M-1] <= PW'(d[M-1]);
      for (int k = 0; k < int'(M); k++)
        m[k] <= MW'(p[k]) * MW'(coef[k]);
      s <= acc_c;
    end
  end

  always_comb begin
    acc_c = '0;
    for (int k = 0; k < int'(M); k++) acc_c = acc_c + ACC_W'(m[k]);
  end

  // Scale, then clamp when the bits above the output sign disagree
  always_comb begin
    shifted_c = s >>> SHIFT;
    hi_c      = shifted_c[ACC_W-1:OUT_W-1];
    res_c     = shifted_c[OUT_W-1:0];
    if (SAT && !((&hi_c) || !(|hi_c)))
      res_c = shifted_c[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      vld       <= {vld[2:0], in_valid};
      out_valid <= vld[3];
      if (vld[3]) out_data <= res_c;
    end
  end

endmodule

// File: tb/tb_fir_sym_pipe.sv
// Scoreboard bench for fir_sym_pipe: a saturating unshifted instance and a
// wrapping SHIFT=1 instance share stimulus and are checked against a tap-sum model.
module tb_fir_sym_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic coef_we = 1'b0;
  logic [2:0] coef_addr = '0;
  logic signed [15:0] coef_wdata = '0;
  logic a_valid, b_valid;
  logic signed [15:0] a_data, b_data;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit last_v = 1'b0;

  typedef struct {longint v; int cyc;} exp_t;
  exp_t qa[$];
  exp_t qb[$];

  longint hist [9];
  longint coef_m [5];

  fir_sym_pipe dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(a_valid), .out_data(a_data)
  );

  fir_sym_pipe #(.SHIFT(1), .SAT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(b_valid), .out_data(b_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: direct 9-tap convolution with mirrored coefficients
  function automatic longint calc(input int sh, input bit sat);
    longint s = 0;
    logic [15:0] lo;
    for (int j = 0; j < 9; j++) s += coef_m[(j <= 4) ? j : 8 - j] * hist[j];
    s = s >>> sh;
    if (sat) begin
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
    end
    lo = s[15:0];
    return longint'($signed(lo));
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < 9; j++) hist[j] = 0;
    for (int k = 0; k < 5; k++) coef_m[k] = (k == 4) ? 1 : 0;
    qa.delete();
    qb.delete();
  endfunction

  // Inputs set here are taken by the next rising edge
  task automatic drive(input bit v, input int x, input bit we, input int addr, input int w);
    exp_t e;
    in_valid   = v;
    in_data    = 16'(x);
    coef_we    = we;
    coef_addr  = 3'(addr);
    coef_wdata = 16'(w);
    if (we && addr < 5) coef_m[addr] = longint'($signed(16'(w)));
    if (v) begin
      for (int j = 8; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = longint'($signed(16'(x)));
      e.cyc = cyc + 5;
      e.v = calc(0, 1'b1); qa.push_back(e);
      e.v = calc(1, 1'b0); qb.push_back(e);
    end
    last_v = v;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic wcoef(input int addr, input int w);
    drive(1'b0, 0, 1'b1, addr, w);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_valid) begin
      if (qa.size() == 0) check("a_unexpected_valid", 1, 0);
      else begin
        e = qa.pop_front();
        check("a_data", longint'(a_data), e.v);
        check("a_latency", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b_valid) begin
      if (qb.size() == 0) check("b_unexpected_valid", 1, 0);
      else begin
        e = qb.pop_front();
        check("b_data", longint'(b_data), e.v);
        check("b_latency", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  initial begin
    int wait_n;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_a_valid", longint'(a_valid), 0);
    check("reset_a_data", longint'(a_data), 0);
    check("reset_b_valid", longint'(b_valid), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Identity filter after reset
    drive(1'b1, 7, 0, 0, 0);
    drive(1'b1, -3, 0, 0, 0);
    drive(1'b1, 100, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(1'b1, 0, 0, 0, 0);
    idle(6);

    // Symmetric impulse response, back-to-back
    wcoef(0, 2); wcoef(1, 0); wcoef(2, 6); wcoef(3, 18); wcoef(4, -32);
    drive(1'b1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1'b1, 0, 0, 0, 0);
    idle(6);

    // Same impulse with a sample every third cycle
    drive(1'b1, 1, 0, 0, 0); idle(2);
    for (int i = 0; i < 10; i++) begin drive(1'b1, 0, 0, 0, 0); idle(2); end
    idle(6);

    // Centre-only full-scale product: clamp on A, wrap on B
    wcoef(0, 0); wcoef(2, 0); wcoef(3, 0); wcoef(4, 32767);
    for (int i = 0; i < 12; i++) drive(1'b1, 32767, 0, 0, 0);
    for (int i = 0; i < 12; i++) drive(1'b1, -32768, 0, 0, 0);
    idle(6);

    // Identity with floor shift on B
    wcoef(4, 1);
    for (int i = 0; i < 6; i++) drive(1'b1, -3, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(1'b1, 3, 0, 0, 0);
    wcoef(6, 123);
    idle(6);

    // Reset in the middle of a burst
    wcoef(4, 5); wcoef(1, -7);
    for (int i = 0; i < 7; i++) drive(1'b1, 1000 + i * 37, 0, 0, 0);
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    check("midrst_a_valid", longint'(a_valid), 0);
    check("midrst_a_data", longint'(a_data), 0);
    check("midrst_b_valid", longint'(b_valid), 0);
    check("midrst_b_data", longint'(b_data), 0);
    model_reset();
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    idle(8);
    for (int i = 0; i < 10; i++) drive(1'b1, -500 + i * 111, 0, 0, 0);
    idle(6);

    // Randomized traffic with coefficient updates away from in-flight mixing
    for (int i = 0; i < 600; i++) begin
      bit v;
      bit we;
      int x;
      v = ($urandom_range(0, 3) != 0);
      we = !last_v && ($urandom_range(0, 5) == 0);
      x = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 32767 : -32768)
                                      : int'($urandom_range(0, 65535)) - 32768;
      drive(v, x, we, int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)) - 32768);
    end

    wait_n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && wait_n < 50) begin
      idle(1);
      wait_n++;
    end
    check("drain_a_empty", longint'(qa.size()), 0);
    check("drain_b_empty", longint'(qb.size()), 0);
    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
